// File: rtl/mem_lsu.sv
// Memory load/store unit between EX_MEM and MEM_WB.
// Formats store lanes and byte enables, runs a single outstanding bus
// access (IDLE/BUSY), sign/zero-extends loads and flags misaligned or
// illegal accesses.
// Optional build macro MEM_LSU_TIMEOUT_EN adds a bus timeout (bus_err_o).
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] RDdata_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUresult_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        access_err_o,
  output logic        bus_err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_lsu: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;

  // Operation captured on BUSY entry, replayed to MEM_WB on completion
  logic [31:0] alu_q;
  logic [4:0]  rd_q;
  logic        regwrite_q;
  logic        memtoreg_q;
  logic        load_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;

  logic [1:0]  lane;
  logic        mem_op;
  logic        illegal_f3;
  logic        misaligned;
  logic        accept;
  logic        busy;
  logic        ack_seen;
  logic        timeout_hit;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign lane     = ALUresult_i[1:0];
  assign mem_op   = MemRead_i | MemWrite_i;
  assign busy     = (state_q == StBusy);
  assign ack_seen = busy & dmem_ack_i;

  // Decode legality and alignment of the presented access
  always_comb begin
    illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    misaligned = 1'b0;
    unique case (funct3_i[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign accept = (state_q == StIdle) & mem_op & ~illegal_f3 & ~misaligned;

`ifdef MEM_LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  // Ack in the same cycle takes priority over the timeout
  assign timeout_hit = busy & ~dmem_ack_i & (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Cycles spent in BUSY without an ack
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt_q <= 8'd0;
    end else if (accept) begin
      tmo_cnt_q <= 8'd0;
    end else if (busy && !dmem_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Stall drops in the completing cycle so upstream advances on that edge
  assign stall_o = accept | (busy & ~dmem_ack_i & ~timeout_hit);

  // Store lane replication and byte enables; loads read the whole word
  always_comb begin
    lane_wdata = RDdata_i;
    lane_be    = 4'b1111;
    if (MemWrite_i) begin
      unique case (funct3_i[1:0])
        2'b00: begin
          lane_wdata = {4{RDdata_i[7:0]}};
          lane_be    = 4'b0001 << lane;
        end
        2'b01: begin
          lane_wdata = {2{RDdata_i[15:0]}};
          lane_be    = lane[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          lane_wdata = RDdata_i;
          lane_be    = 4'b1111;
        end
      endcase
    end
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    rd_byte = dmem_rdata_i[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    unique case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (ack_seen || timeout_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, bus request and MEM_WB output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      alu_q        <= 32'd0;
      rd_q         <= 5'd0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      load_q       <= 1'b0;
      lane_q       <= 2'd0;
      funct3_q     <= 3'd0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
      dmem_be_o    <= 4'd0;
      ReadData_o   <= 32'd0;
      ALUresult_o  <= 32'd0;
      RDaddr_o     <= 5'd0;
      RegWrite_o   <= 1'b0;
      MemToReg_o   <= 1'b0;
      access_err_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      access_err_o <= 1'b0;
      bus_err_o    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            alu_q        <= ALUresult_i;
            rd_q         <= RDaddr_i;
            regwrite_q   <= RegWrite_i;
            memtoreg_q   <= MemToReg_i;
            load_q       <= MemRead_i;
            lane_q       <= lane;
            funct3_q     <= funct3_i;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= MemWrite_i;
            dmem_addr_o  <= {ALUresult_i[31:2], 2'b00};
            dmem_wdata_o <= lane_wdata;
            dmem_be_o    <= lane_be;
            RegWrite_o   <= 1'b0;
          end else begin
            // Plain ALU op, or a rejected memory op that must not write back
            ALUresult_o  <= ALUresult_i;
            RDaddr_o     <= RDaddr_i;
            MemToReg_o   <= MemToReg_i;
            RegWrite_o   <= RegWrite_i & ~mem_op;
            access_err_o <= mem_op;
          end
        end
        StBusy: begin
          if (dmem_ack_i) begin
            dmem_req_o  <= 1'b0;
            dmem_we_o   <= 1'b0;
            ALUresult_o <= alu_q;
            RDaddr_o    <= rd_q;
            RegWrite_o  <= regwrite_q;
            MemToReg_o  <= memtoreg_q;
            if (load_q) ReadData_o <= load_data;
          end else if (timeout_hit) begin
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            RegWrite_o <= 1'b0;
            bus_err_o  <= 1'b1;
          end else begin
            RegWrite_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized ops
// checked against a behavioural model of the load/store rules.
module tb_mem_lsu;

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int unsigned Tmo = 4;
`else
  localparam int unsigned Tmo = 16;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ALUresult_i, RDdata_i, dmem_rdata_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, dmem_ack_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o, stall_o, RegWrite_o, MemToReg_o;
  logic        access_err_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, ReadData_o, ALUresult_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  RDaddr_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_rd = 32'd0;

  always #5 CLK = ~CLK;

  mem_lsu #(.TIMEOUT_CYCLES(Tmo)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ALUresult_i  (ALUresult_i),
    .RDdata_i     (RDdata_i),
    .RDaddr_i     (RDaddr_i),
    .RegWrite_i   (RegWrite_i),
    .MemToReg_i   (MemToReg_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .funct3_i     (funct3_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .ReadData_o   (ReadData_o),
    .ALUresult_o  (ALUresult_o),
    .RDaddr_o     (RDaddr_o),
    .RegWrite_o   (RegWrite_o),
    .MemToReg_o   (MemToReg_o),
    .access_err_o (access_err_o),
    .bus_err_o    (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit access_ok(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    if (sz == 0) return 0;
    return (addr % sz) == 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (addr % 4));
    case (f3)
      3'b000:  begin v = v % 256;   return (v >= 128)   ? v - 256   : v; end
      3'b100:  return v % 256;
      3'b001:  begin v = v % 65536; return (v >= 32768) ? v - 65536 : v; end
      3'b101:  return v % 65536;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] store_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    return ((32'd1 << sz) - 1) << (addr % 4);
  endfunction

  task automatic idle_inputs();
    ALUresult_i = 0; RDdata_i = 0; RDaddr_i = 0; RegWrite_i = 0; MemToReg_i = 0;
    MemRead_i = 0; MemWrite_i = 0; funct3_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  // kind: 0 ALU op, 1 load, 2 store; dly = BUSY cycles before the ack cycle
  task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int dly,
                        input logic [4:0] rd, input logic rw, input logic m2r);
    bit bad;
    int stall_hi;
    @(posedge CLK); #1;
    ALUresult_i = addr; RDdata_i = data; RDaddr_i = rd; RegWrite_i = rw; MemToReg_i = m2r;
    MemRead_i = (kind == 1); MemWrite_i = (kind == 2); funct3_i = f3;
    dmem_ack_i = 0; dmem_rdata_i = $urandom;
    bad = (kind != 0) && !access_ok(f3, addr);
    #1;
    chk("stall_present", {31'd0, stall_o}, {31'd0, kind != 0 && !bad});
    if (kind == 0 || bad) begin
      @(posedge CLK); #1;
      chk("direct_regwrite", {31'd0, RegWrite_o}, {31'd0, rw && !bad});
      chk("direct_alu", ALUresult_o, addr);
      chk("direct_rd", {27'd0, RDaddr_o}, {27'd0, rd});
      chk("direct_m2r", {31'd0, MemToReg_o}, {31'd0, m2r});
      chk("access_err", {31'd0, access_err_o}, {31'd0, bad});
      chk("direct_noreq", {31'd0, dmem_req_o}, 32'd0);
      chk("direct_readdata", ReadData_o, model_rd);
    end else begin
      stall_hi = 1;
      @(posedge CLK); #1;
      chk("busy_req", {31'd0, dmem_req_o}, 32'd1);
      chk("busy_we", {31'd0, dmem_we_o}, {31'd0, kind == 2});
      chk("busy_be", {28'd0, dmem_be_o}, (kind == 2) ? store_be(f3, addr) : 32'hF);
      if (kind == 2) chk("busy_wdata", dmem_wdata_o, store_wdata(f3, data));
      for (int k = 0; k <= dly; k++) begin
        if (k == dly) begin dmem_ack_i = 1; dmem_rdata_i = rdata; end
        #1;
        chk("busy_addr", dmem_addr_o, addr - (addr % 4));
        chk("busy_regwrite_bubble", {31'd0, RegWrite_o}, 32'd0);
        chk("busy_stall", {31'd0, stall_o}, {31'd0, k != dly});
        if (stall_o) stall_hi++;
        if (k != dly) begin @(posedge CLK); #1; end
      end
      @(posedge CLK); #1;
      dmem_ack_i = 0;
      if (kind == 1) model_rd = load_val(f3, addr, rdata);
      chk("done_req", {31'd0, dmem_req_o}, 32'd0);
      chk("done_regwrite", {31'd0, RegWrite_o}, {31'd0, rw});
      chk("done_alu", ALUresult_o, addr);
      chk("done_rd", {27'd0, RDaddr_o}, {27'd0, rd});
      chk("done_m2r", {31'd0, MemToReg_o}, {31'd0, m2r});
      chk("done_readdata", ReadData_o, model_rd);
      chk("stall_cycles", stall_hi, dly + 1);
    end
    chk("bus_err_quiet", {31'd0, bus_err_o}, 32'd0);
    MemRead_i = 0; MemWrite_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [6];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
    idle_inputs();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_readdata", ReadData_o, 32'd0);
    chk("rst_regwrite", {31'd0, RegWrite_o}, 32'd0);
    RESET = 0;

    // LW 0x100, ack on 3rd BUSY cycle
    run_op(1, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 5'd7, 1'b1, 1'b1);
    // SB 0x203 data A5
    run_op(2, 3'b000, 32'h203, 32'hA5, 32'h0, 1, 5'd0, 1'b0, 1'b0);
    // LH / LHU 0x102
    run_op(1, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0, 5'd3, 1'b1, 1'b1);
    run_op(1, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 1, 5'd4, 1'b1, 1'b1);
    // Misaligned LW
    run_op(1, 3'b010, 32'h102, 32'h0, 32'h0, 0, 5'd9, 1'b1, 1'b1);
    // Ack while idle is ignored
    @(posedge CLK); #1;
    dmem_ack_i = 1;
    @(posedge CLK); #1;
    chk("idle_ack_req", {31'd0, dmem_req_o}, 32'd0);
    chk("idle_ack_readdata", ReadData_o, model_rd);
    dmem_ack_i = 0;

    // Reset during BUSY, then a late ack
    @(posedge CLK); #1;
    ALUresult_i = 32'h300; RDaddr_i = 5'd5; RegWrite_i = 1; MemRead_i = 1; funct3_i = 3'b010;
    @(posedge CLK); #1;
    chk("pre_rst_req", {31'd0, dmem_req_o}, 32'd1);
    RESET = 1; idle_inputs();
    @(posedge CLK); #1;
    RESET = 0;
    model_rd = 0;
    chk("midrst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("midrst_alu", ALUresult_o, 32'd0);
    chk("midrst_readdata", ReadData_o, 32'd0);
    dmem_ack_i = 1; dmem_rdata_i = 32'h1234_5678;
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge CLK); #1;
    dmem_ack_i = 0;
    chk("late_ack_req", {31'd0, dmem_req_o}, 32'd0);
    chk("late_ack_readdata", ReadData_o, 32'd0);
    chk("late_ack_regwrite", {31'd0, RegWrite_o}, 32'd0);

`ifdef MEM_LSU_TIMEOUT_EN
    // No ack: timeout after Tmo BUSY cycles
    @(posedge CLK); #1;
    ALUresult_i = 32'h400; RDaddr_i = 5'd6; RegWrite_i = 1; MemRead_i = 1; funct3_i = 3'b010;
    @(posedge CLK); #1;
    for (int k = 0; k < Tmo; k++) begin
      chk("tmo_req", {31'd0, dmem_req_o}, 32'd1);
      chk("tmo_stall", {31'd0, stall_o}, {31'd0, k != Tmo - 1});
      chk("tmo_no_err", {31'd0, bus_err_o}, 32'd0);
      @(posedge CLK); #1;
    end
    MemRead_i = 0;
    chk("tmo_bus_err", {31'd0, bus_err_o}, 32'd1);
    chk("tmo_req_drop", {31'd0, dmem_req_o}, 32'd0);
    chk("tmo_regwrite", {31'd0, RegWrite_o}, 32'd0);
    @(posedge CLK); #1;
    chk("tmo_err_pulse", {31'd0, bus_err_o}, 32'd0);
    chk("tmo_idle_stall", {31'd0, stall_o}, 32'd0);
`endif

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [2:0] f3;
      kind = $urandom_range(0, 2);
      f3 = (kind == 2) ? st_f3[$urandom_range(0, 5)] : ld_f3[$urandom_range(0, 4)];
      if (kind == 1 && $urandom_range(0, 9) == 0) f3 = 3'b110;
      run_op(kind, f3, $urandom, $urandom, $urandom, $urandom_range(0, 2),
             5'($urandom), (kind == 2) ? 1'b0 : 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
